// File: rtl/simple_fifo_if.sv
// Producer/consumer handshake bundle for simple_fifo: push side, pop side and status flags.
interface simple_fifo_if #(
  parameter int width   = 8,
  parameter int widthad = 4
);
  logic               wrreq;
  logic [width-1:0]   data;
  logic               full;
  logic               rdreq;
  logic [width-1:0]   q;
  logic               empty;
  logic [widthad:0]   usedw;
  logic               overflow;
  logic               underflow;

  modport master (
    output wrreq, data, rdreq,
    input  full, q, empty, usedw, overflow, underflow
  );

  modport slave (
    input  wrreq, data, rdreq,
    output full, q, empty, usedw, overflow, underflow
  );
endinterface

// File: rtl/simple_fifo.sv
// Show-ahead synchronous FIFO built around a dual-port array with a registered read
// address; the next head is fetched in the same edge that pops the current one.
module simple_fifo #(
  parameter int width   = 8,
  parameter int widthad = 4
) (
  input  logic         clk,
  input  logic         rst,
  simple_fifo_if.slave bus
);
  localparam int depth = 2 ** widthad;

  logic [width-1:0]   mem [depth];
  logic [widthad-1:0] wr_ptr, rd_ptr;
  logic [widthad-1:0] wraddress, rdaddress, rd_addr_q;
  logic               wren;
  logic [widthad:0]   usedw_r, usedw_next;
  logic               head_valid;
  logic               overflow_r, underflow_r;
  logic               full, push, pop, collide;

  assign full = (usedw_r == (widthad + 1)'(depth));
  assign push = bus.wrreq && !full;
  assign pop  = bus.rdreq && head_valid;

  assign wraddress = wr_ptr;
  assign wren      = push;
  assign rdaddress = rd_ptr + widthad'(pop);

  // The array has no write-through, so a word written to the address being fetched
  // only becomes readable one edge later; head_valid waits for it.
  assign collide = push && (wraddress == rdaddress);

  // NOTE: every variable in a combinational block gets a default first; otherwise a
  // missing branch infers a latch.
  always_comb begin
    usedw_next = usedw_r;
    if (push && !pop)      usedw_next = usedw_r + 1'b1;
    else if (pop && !push) usedw_next = usedw_r - 1'b1;
  end

  // NOTE: storage is deliberately not reset; only the pointers and flags are, and
  // q is never trusted while empty is high.
  always_ff @(posedge clk) begin
    if (wren) mem[wraddress] <= bus.data;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_addr_q   <= '0;
      usedw_r     <= '0;
      head_valid  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr      <= rdaddress;
      rd_addr_q   <= rdaddress;
      usedw_r     <= usedw_next;
      head_valid  <= (usedw_next != '0) && !collide;
      overflow_r  <= bus.wrreq && full;
      underflow_r <= bus.rdreq && !head_valid;
    end
  end

  assign bus.q         = mem[rd_addr_q];
  assign bus.empty     = !head_valid;
  assign bus.full      = full;
  assign bus.usedw     = usedw_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_simple_fifo.sv
// Randomised and directed bench for simple_fifo (width 8, depth 4) against a
// queue-based reference model of the show-ahead behaviour.
module tb_simple_fifo;
  localparam int width   = 8;
  localparam int widthad = 2;
  localparam int depth   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simple_fifo_if #(.width(width), .widthad(widthad)) bus ();
  simple_fifo #(.width(width), .widthad(widthad)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue plus the expected flag values.
  logic [width-1:0] model_q[$];
  bit               m_empty = 1'b1;
  bit               m_ovf   = 1'b0;
  bit               m_udf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("usedw", 32'(bus.usedw), 32'(model_q.size()));
    check("full", 32'(bus.full), 32'(model_q.size() == depth));
    check("empty", 32'(bus.empty), 32'(m_empty));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
    if (!m_empty) check("q", 32'(bus.q), 32'(model_q[0]));
  endtask

  // One clock: drive requests, let the edge happen, update the model, check.
  task automatic step(input bit r, input bit wr, input logic [width-1:0] d, input bit rd);
    int  size_before;
    bit  full_before, push, pop;
    rst       = r;
    bus.wrreq = wr;
    bus.data  = d;
    bus.rdreq = rd;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_empty = 1'b1;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      size_before = model_q.size();
      full_before = (size_before == depth);
      push  = wr && !full_before;
      pop   = rd && !m_empty;
      m_ovf = wr && full_before;
      m_udf = rd && m_empty;
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(d);
      // A word that becomes the head in the same edge it is written is visible one cycle late.
      m_empty = (model_q.size() == 0) || (push && (size_before - int'(pop) == 0));
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [width-1:0] pat;
    rst = 1'b1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = '0;

    // Reset, then idle.
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h55, 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Push into empty: usedw after N, head after N+1.
    step(0, 1, 8'hA1, 0);
    check("first_push_empty_hold", 32'(bus.empty), 32'd1);
    step(0, 0, 8'h00, 0);
    check("first_push_q", 32'(bus.q), 32'hA1);
    step(0, 0, 8'h00, 1);

    // Fill, overflow, drain back-to-back, underflow.
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0);
    check("full_flag", 32'(bus.full), 32'd1);
    step(0, 1, 8'h05, 0);
    check("overflow_pulse", 32'(bus.overflow), 32'd1);
    step(0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) begin
      check("drain_q", 32'(bus.q), 32'(i));
      step(0, 0, 8'h00, 1);
    end
    check("drained_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 8'h00, 1);
    check("underflow_pulse", 32'(bus.underflow), 32'd1);
    step(0, 0, 8'h00, 0);

    // Simultaneous push/pop at usedw == 1.
    step(0, 1, 8'h10, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h20, 1);
    check("rdw_hold_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 8'h00, 0);
    check("rdw_new_head", 32'(bus.q), 32'h20);
    step(0, 0, 8'h00, 1);

    // Wrap-around streaming at usedw == 2.
    pat = 8'h30;
    step(0, 1, pat, 0); pat++;
    step(0, 1, pat, 0); pat++;
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, pat, 1);
      pat++;
    end

    // Reset mid-stream with usedw == 3.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h40 + 8'(i), 0);
    check("pre_reset_usedw", 32'(bus.usedw), 32'd3);
    step(1, 1, 8'h77, 1);
    step(0, 0, 8'h00, 0);

    // Randomised traffic with shifting push/pop bias.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 50) % 3;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < (bias == 0 ? 75 : (bias == 1 ? 30 : 50))),
           8'($urandom()),
           ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 75 : 50))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_fifo.md
Name: simple_fifo

Overview:
- Synchronous show-ahead FIFO; the write/read client of a dual-port RAM that has a registered read address and one-cycle read latency.
- Owns the RAM write port (wraddress/wren/data) and read port (rdaddress/q). Presents a request/flag interface to producers and consumers in the same clock domain.
- Used for command and data buffering between ao486 pipeline stages and peripheral bridges.

Parameters:
- width, 8: data word width in bits.
- widthad, 4: address width. Capacity DEPTH = 2**widthad entries.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- wrreq  input  1  push request.
- data  input  width  push data, sampled when wrreq && !full.
- full  output  1  usedw == DEPTH.
- rdreq  input  1  pop request (acknowledge of the current head).
- q  output  width  head entry; valid only while empty == 0.
- empty  output  1  no valid head presented.
- usedw  output  widthad+1  count of accepted, not yet popped entries (0..DEPTH).
- overflow  output  1  one-cycle pulse: wrreq && full at that edge.
- underflow  output  1  one-cycle pulse: rdreq && empty at that edge.

Behaviour:
- Storage: internal 2**widthad x width array.
  - Written at the clock edge.
  - Read address is registered at the edge; q is the array word at the registered address.
  - No read-during-write bypass through the array.
- Pointers:
  - wr_ptr and rd_ptr are widthad bits and wrap modulo DEPTH.
  - rdaddress presented to the array is rd_ptr + pop, so the next head is fetched in the same edge as the pop.
- push = wrreq && !full; pop = rdreq && !empty. Both use flags sampled before the edge.
- usedw:
  - +1 on push only; -1 on pop only; unchanged on both or neither.
  - Updates at the edge of the accepted request.
- full: combinational from usedw. Writes while full are rejected even if a pop happens at the same edge.
- empty / head_valid register:
  - head_valid = 1 after an edge where usedw_next >= 1, except when the head entry was written at that same edge (the read-during-write case).
  - In that case head_valid = 0 for one cycle and rises at the next edge.
  - empty = !head_valid.
- Latencies:
  - Push into an empty FIFO at edge N: usedw = 1 after N; empty = 0 and q = data after N+1.
  - Pop at edge M with usedw >= 2 before M: q = next entry after M, empty stays 0. Back-to-back pops run every cycle.
  - Pop with usedw == 1 and no push: empty = 1 after M.
  - Simultaneous push and pop with usedw == 1: usedw stays 1; empty = 1 for one cycle, then q = the new word.
- Overflow / underflow:
  - overflow/underflow are registered pulses, high for exactly the cycle after the offending edge.
  - State is unchanged by rejected requests.
- Reset (rst high at an edge, including mid-transfer):
  - wr_ptr = rd_ptr = 0, usedw = 0, empty = 1, full = 0, overflow = underflow = 0.
  - Any requests in the reset cycle are ignored.
  - Array contents are not cleared; q is don't-care while empty.
- No X propagation from the uninitialised array into the flags.

Test Plan:
(All with width = 8, widthad = 2, DEPTH = 4.)
- Reset then idle -> empty = 1, full = 0, usedw = 0, no pulses. Assert rst mid-stream with usedw = 3 -> all flags back to reset values after one edge.
- Push 0xA1 into empty at edge N -> usedw = 1 after N; empty = 0 and q = 0xA1 after N+1.
- Push 0x01..0x04 on consecutive cycles -> full = 1, usedw = 4. Push 0x05 -> overflow pulses once, usedw stays 4. Pop four times back-to-back -> q sequence 0x01, 0x02, 0x03, 0x04, then empty = 1.
- Pop while empty -> underflow pulses one cycle; usedw stays 0, empty stays 1.
- usedw = 1 (head 0x10), push 0x20 and pop at the same edge -> usedw = 1; empty = 1 for one cycle; then q = 0x20.
- Wrap-around: 10 cycles of simultaneous push/pop at usedw = 2 with an incrementing pattern -> popped data strictly in order, usedw constant at 2, no overflow/underflow pulses.
